record_play_sequencer: RTL and testbench
========================================

RECORD_PLAY_SEQUENCER -- requirements
Module: record_play_sequencer

Interface
REQ-001 SHALL have parameter LOOP_WIDTH, default 8, the width of the replay loop count.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 16, the width of the stall watchdog counter.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, the number of cycles play is held low between loops; legal range 1..15.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-007 cmd_op  input  2  command: 01 CAPTURE, 10 REPLAY; 00/11 accepted and ignored.
REQ-008 cmd_loops  input  LOOP_WIDTH  replay repetitions; 0 is treated as 1.
REQ-009 abort  input  1  level; terminates any operation.
REQ-010 rec_valid, rec_ready, rec_last  input  1 each  monitored capture stream beat.
REQ-011 ply_valid, ply_ready, ply_last  input  1 each  monitored playback stream beat.
REQ-012 record, play  output  1 each  levels driven to the recorder/player.
REQ-013 busy, done, error  output  1 each  status; done and error are single-cycle pulses.
REQ-014 err_code  output  2  01 timeout, 10 replay without capture, 11 aborted; 00 none.
REQ-015 loops_done  output  LOOP_WIDTH  completed replay loops of the current or last replay.

Function
REQ-016 States: IDLE, CAPTURE, REPLAY, GAP, DONE; state is registered.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-018 Accepted CAPTURE in cycle N: state CAPTURE and record=1 from N+1; have_capture flag cleared.
REQ-019 Accepted REPLAY with have_capture=1: state REPLAY and play=1 from N+1; target=max(cmd_loops,1); loops_done cleared.
REQ-020 Accepted REPLAY with have_capture=0: stay IDLE; error pulse at N+1; err_code=10.
REQ-021 Outputs SHALL decode from state: record=(CAPTURE), play=(REPLAY), busy=(not IDLE), done=(DONE).
REQ-022 In CAPTURE, rec_valid&rec_ready&rec_last SHALL move to DONE and set have_capture.
REQ-023 In REPLAY, ply_valid&ply_ready&ply_last SHALL increment loops_done; if the new value equals target, go to DONE, else go to GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles with play=0, then return to REPLAY.
REQ-025 DONE SHALL last one cycle, then return to IDLE.
REQ-026 Watchdog: cleared on entry to CAPTURE/REPLAY and on every monitored valid&ready beat; increments each other cycle in CAPTURE/REPLAY; frozen in GAP.
REQ-027 When the watchdog reaches all-ones: go to IDLE, error pulse next cycle, err_code=01, have_capture unchanged.
REQ-028 abort in any non-IDLE state: go to IDLE next cycle, error pulse, err_code=11; an abort during CAPTURE clears have_capture.
REQ-029 Priority within one cycle: abort > completion (last beat) > watchdog expiry.
REQ-030 abort in IDLE SHALL have no effect; commands presented with abort high in IDLE SHALL still be accepted.
REQ-031 err_code SHALL hold until the next accepted CAPTURE/REPLAY, which clears it to 00.
REQ-032 loops_done SHALL saturate at 2^LOOP_WIDTH-1 and hold after DONE until the next REPLAY.

Reset
REQ-033 During and after reset: state IDLE, record=0, play=0, busy=0, done=0, error=0, err_code=00, loops_done=0, have_capture=0, watchdog=0, cmd_ready=1.
REQ-034 Reset asserted mid-operation SHALL force the reset values on the next edge with no done or error pulse.

Verification
REQ-035 REPLAY immediately after reset -> no play, error pulse one cycle, err_code=10, cmd_ready stays 1.
REQ-036 CAPTURE, 5 beats with last on beat 5 -> record high for those cycles, done pulse the cycle after beat 5, busy low one cycle after done.
REQ-037 REPLAY cmd_loops=3, GAP_CYCLES=2, 4-beat playback -> three play windows separated by 2 low cycles, loops_done=3, single done pulse.
REQ-038 REPLAY cmd_loops=0 -> behaves as 1 loop, loops_done=1.
REQ-039 TIMEOUT_WIDTH=4, CAPTURE with rec_valid held low -> error pulse 15 cycles after entry, err_code=01, record=0.
REQ-040 abort in the same cycle as the final ply_last beat -> err_code=11, no done pulse; resetn low during REPLAY -> play=0 next cycle, no pulses.

Source files
------------

// File: rtl/record_play_sequencer.sv
// Record/play sequencer: captures one recording, then replays it a commanded number of loops
// with a fixed play-low gap between loops, guarded by a stall watchdog and an abort input.
module record_play_sequencer #(
    parameter int unsigned LOOP_WIDTH    = 8,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LOOP_WIDTH-1:0] cmd_loops,
    input  logic                  abort,
    input  logic                  rec_valid,
    input  logic                  rec_ready,
    input  logic                  rec_last,
    input  logic                  ply_valid,
    input  logic                  ply_ready,
    input  logic                  ply_last,
    output logic                  record,
    output logic                  play,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [LOOP_WIDTH-1:0] loops_done
);

    typedef enum logic [2:0] {StIdle, StCapture, StReplay, StGap, StDone} state_t;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrTimeout = 2'b01;
    localparam logic [1:0] ErrNoCap   = 2'b10;
    localparam logic [1:0] ErrAbort   = 2'b11;

    state_t                   state_q, state_d;
    logic                     have_capture_q, have_capture_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic [3:0]               gap_q, gap_d;
    logic [LOOP_WIDTH-1:0]    target_q, target_d;
    logic [LOOP_WIDTH-1:0]    loops_q, loops_d;
    logic [1:0]               err_code_q, err_code_d;
    logic                     error_q, error_d;

    logic                     rec_beat, ply_beat, wd_expire;
    logic [TIMEOUT_WIDTH-1:0] wd_inc;
    logic [LOOP_WIDTH-1:0]    loops_inc;

    assign rec_beat  = rec_valid && rec_ready;
    assign ply_beat  = ply_valid && ply_ready;
    assign wd_inc    = wd_q + 1'b1;
    // Expire on the cycle whose increment would bring the watchdog to all-ones.
    assign wd_expire = &wd_inc;
    assign loops_inc = (&loops_q) ? loops_q : loops_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        have_capture_d = have_capture_q;
        wd_d           = wd_q;
        gap_d          = gap_q;
        target_d       = target_q;
        loops_d        = loops_q;
        err_code_d     = err_code_q;
        error_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b01: begin
                            state_d        = StCapture;
                            have_capture_d = 1'b0;
                            err_code_d     = ErrNone;
                            wd_d           = '0;
                        end
                        2'b10: begin
                            if (have_capture_q) begin
                                state_d    = StReplay;
                                target_d   = (cmd_loops == '0) ? LOOP_WIDTH'(1) : cmd_loops;
                                loops_d    = '0;
                                err_code_d = ErrNone;
                                wd_d       = '0;
                            end else begin
                                err_code_d = ErrNoCap;
                                error_d    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d        = StIdle;
                    have_capture_d = 1'b0;
                    err_code_d     = ErrAbort;
                    error_d        = 1'b1;
                end else if (rec_beat && rec_last) begin
                    state_d        = StDone;
                    have_capture_d = 1'b1;
                end else if (rec_beat) begin
                    wd_d = '0;
                end else if (wd_expire) begin
                    state_d    = StIdle;
                    err_code_d = ErrTimeout;
                    error_d    = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StReplay: begin
                if (abort) begin
                    state_d    = StIdle;
                    err_code_d = ErrAbort;
                    error_d    = 1'b1;
                end else if (ply_beat && ply_last) begin
                    loops_d = loops_inc;
                    gap_d   = '0;
                    state_d = (loops_inc == target_q) ? StDone : StGap;
                end else if (ply_beat) begin
                    wd_d = '0;
                end else if (wd_expire) begin
                    state_d    = StIdle;
                    err_code_d = ErrTimeout;
                    error_d    = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d    = StIdle;
                    err_code_d = ErrAbort;
                    error_d    = 1'b1;
                end else if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = StReplay;
                    wd_d    = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (abort) begin
                    err_code_d = ErrAbort;
                    error_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StIdle;
            have_capture_q <= 1'b0;
            wd_q           <= '0;
            gap_q          <= '0;
            target_q       <= LOOP_WIDTH'(1);
            loops_q        <= '0;
            err_code_q     <= ErrNone;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            have_capture_q <= have_capture_d;
            wd_q           <= wd_d;
            gap_q          <= gap_d;
            target_q       <= target_d;
            loops_q        <= loops_d;
            err_code_q     <= err_code_d;
            error_q        <= error_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign record     = (state_q == StCapture);
    assign play       = (state_q == StReplay);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign loops_done = loops_q;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Self-checking bench for record_play_sequencer: vector table, directed corner sequences and
// randomized traffic compared every cycle against an event-level reference model.
module tb_record_play_sequencer;

    localparam int LW   = 8;
    localparam int TW   = 4;
    localparam int GC   = 2;
    localparam int TMAX = (1 << TW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk, resetn;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_loops;
    logic          abort;
    logic          rec_valid, rec_ready, rec_last;
    logic          ply_valid, ply_ready, ply_last;
    logic          record, play, busy, done, error;
    logic [1:0]    err_code;
    logic [LW-1:0] loops_done;

    record_play_sequencer #(
        .LOOP_WIDTH   (LW),
        .TIMEOUT_WIDTH(TW),
        .GAP_CYCLES   (GC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_loops (cmd_loops),
        .abort     (abort),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_last  (rec_last),
        .ply_valid (ply_valid),
        .ply_ready (ply_ready),
        .ply_last  (ply_last),
        .record    (record),
        .play      (play),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .loops_done(loops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 recording, 2 playing, 3 gap, 4 finished.
    int m_mode, m_stall, m_gap_left, m_loops, m_target, m_err;
    bit m_have, m_pulse;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic stall_step(input bit beat);
        if (beat) m_stall = 0;
        else if (m_stall + 1 == TMAX) begin
            m_mode = 0; m_err = 1; m_pulse = 1;
        end else m_stall++;
    endtask

    task automatic model_step();
        bit rb, pb;
        rb = rec_valid && rec_ready;
        pb = ply_valid && ply_ready;
        m_pulse = 0;
        if (!resetn) begin
            m_mode = 0; m_stall = 0; m_gap_left = 0; m_loops = 0; m_target = 1;
            m_err = 0; m_have = 0;
        end else if (m_mode != 0 && abort) begin
            if (m_mode == 1) m_have = 0;
            m_mode = 0; m_err = 3; m_pulse = 1;
        end else begin
            case (m_mode)
                0: if (cmd_valid) begin
                    if (cmd_op == 2'b01) begin
                        m_mode = 1; m_have = 0; m_err = 0; m_stall = 0;
                    end else if (cmd_op == 2'b10) begin
                        if (m_have) begin
                            m_mode = 2; m_loops = 0; m_err = 0; m_stall = 0;
                            m_target = (cmd_loops == 0) ? 1 : int'(cmd_loops);
                        end else begin
                            m_err = 2; m_pulse = 1;
                        end
                    end
                end
                1: if (rb && rec_last) begin
                    m_mode = 4; m_have = 1;
                end else stall_step(rb);
                2: if (pb && ply_last) begin
                    m_loops    = (m_loops < LMAX) ? m_loops + 1 : LMAX;
                    m_mode     = (m_loops == m_target) ? 4 : 3;
                    m_gap_left = GC;
                end else stall_step(pb);
                3: begin
                    m_gap_left--;
                    if (m_gap_left == 0) begin m_mode = 2; m_stall = 0; end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    function automatic logic [15:0] model_out();
        return {m_mode == 0, m_mode == 1, m_mode == 2, m_mode != 0, m_mode == 4, m_pulse,
                2'(m_err), 8'(m_loops)};
    endfunction

    function automatic logic [15:0] dut_out();
        return {cmd_ready, record, play, busy, done, error, err_code, loops_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", dut_out(), model_out());
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd_op = 0; cmd_loops = 0; abort = 0;
        rec_valid = 0; rec_ready = 0; rec_last = 0;
        ply_valid = 0; ply_ready = 0; ply_last = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [LW-1:0] loops);
        cmd_valid = 1; cmd_op = op; cmd_loops = loops;
        tick();
        clear_inputs();
    endtask

    typedef struct {
        logic       cv;
        logic [1:0] op;
        logic       rv, rr, rl;
        logic [7:0] exp; // {ready, record, play, busy, done, error, err_code}
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] play_bits, exp_bits;
        int          done_cnt, n;

        tbl[0] = '{1, 2'b10, 0, 0, 0, 8'b10000110};
        tbl[1] = '{0, 2'b00, 0, 0, 0, 8'b10000010};
        tbl[2] = '{1, 2'b01, 0, 0, 0, 8'b01010000};
        tbl[3] = '{0, 2'b00, 1, 1, 0, 8'b01010000};
        tbl[4] = '{0, 2'b00, 1, 0, 1, 8'b01010000};
        tbl[5] = '{0, 2'b00, 1, 1, 0, 8'b01010000};
        tbl[6] = '{0, 2'b00, 1, 1, 0, 8'b01010000};
        tbl[7] = '{0, 2'b00, 1, 1, 0, 8'b01010000};
        tbl[8] = '{0, 2'b00, 1, 1, 1, 8'b00011000};
        tbl[9] = '{0, 2'b00, 0, 0, 0, 8'b10000000};

        clear_inputs();
        resetn = 0;
        tick();
        tick();
        check("reset_outputs", dut_out(), 16'h8000);
        resetn = 1;

        // Replay before any capture, then a 5-beat capture with one stalled cycle.
        for (int i = 0; i < 10; i++) begin
            cmd_valid = tbl[i].cv; cmd_op = tbl[i].op;
            rec_valid = tbl[i].rv; rec_ready = tbl[i].rr; rec_last = tbl[i].rl;
            tick();
            check($sformatf("vec%0d", i), {cmd_ready, record, play, busy, done, error, err_code},
                  {24'd0, tbl[i].exp});
        end
        clear_inputs();

        // Three 4-beat loops with two gap cycles between them.
        send(2'b10, 8'd3);
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            play_bits[c] = play;
            exp_bits[c]  = (c % 6) < 4;
            done_cnt    += int'(done);
            ply_valid = (c % 6) < 4; ply_ready = ply_valid; ply_last = (c % 6) == 3;
            tick();
        end
        clear_inputs();
        check("play_windows", play_bits, exp_bits);
        check("replay3_done", done, 1);
        check("replay3_loops", loops_done, 3);
        done_cnt += int'(done);
        tick();
        done_cnt += int'(done);
        check("replay3_done_count", done_cnt, 1);
        check("replay3_loops_hold", {busy, loops_done}, {1'b0, 8'd3});

        // Zero loops behaves as one.
        send(2'b10, 8'd0);
        ply_valid = 1; ply_ready = 1; ply_last = 1;
        tick();
        clear_inputs();
        check("loops0_done", {done, loops_done}, {1'b1, 8'd1});
        tick();

        // Capture stalled until the watchdog fires.
        send(2'b01, 8'd0);
        n = 0;
        while (!error && n < 40) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 15);
        check("timeout_code", {record, err_code}, {1'b0, 2'b01});

        // Abort coincident with the final playback beat.
        send(2'b01, 8'd0);
        rec_valid = 1; rec_ready = 1; rec_last = 1;
        tick();
        clear_inputs();
        tick();
        send(2'b10, 8'd1);
        ply_valid = 1; ply_ready = 1; ply_last = 1; abort = 1;
        tick();
        clear_inputs();
        check("abort_last", {done, error, err_code}, {1'b0, 1'b1, 2'b11});
        tick();
        check("abort_last_after", {done, busy, error}, 3'b000);

        // Reset in the middle of a replay.
        send(2'b10, 8'd2);
        tick();
        check("replay_running", play, 1);
        resetn = 0;
        tick();
        check("midreset", dut_out(), 16'h8000);
        resetn = 1;

        // Abort held in idle does not block a command; it then aborts the capture.
        cmd_valid = 1; cmd_op = 2'b01; abort = 1;
        tick();
        clear_inputs();
        abort = 1;
        check("abort_idle_accept", record, 1);
        tick();
        clear_inputs();
        check("abort_capture", {record, error, err_code}, {1'b0, 1'b1, 2'b11});

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            quiet     = ((i / 200) % 3) == 2;
            resetn    = $urandom_range(0, 299) != 0;
            cmd_valid = $urandom_range(0, 9) < 3;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_loops = 8'($urandom_range(0, 3));
            abort     = $urandom_range(0, 49) == 0;
            rec_valid = quiet ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            rec_ready = $urandom_range(0, 9) < 8;
            rec_last  = $urandom_range(0, 3) == 0;
            ply_valid = quiet ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            ply_ready = $urandom_range(0, 9) < 8;
            ply_last  = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
